bus_xfer_ctrl: RTL
==================

Name: bus_xfer_ctrl

Overview:
Parametrised, registered successor to the datapath's combinational bus multiplexer. It selects one of N_SRC source registers onto a registered bus, then pulses write enables to one or more destination registers. Each transfer follows a req/ready/done handshake. The block sits between the control unit (which issues transfers) and the register file, memories and accumulator, and adds illegal-select detection and a transfer counter.

Parameters:
DATA_W, 16, bus width in bits; sources narrower than this are zero-extended by the caller
N_SRC, 8, number of source slots
N_DST, 8, number of destination write-enable lines
SRC_EN, 8'b1111_0111, bitmask of implemented source slots; slot 3 is unused by default
ILLEGAL_ZERO, 1, 1: an illegal select drives busout to 0; 0: busout holds its previous value
CNT_W, 8, width of the transfer counter
(localparam SEL_W = clog2(N_SRC), minimum 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
xfer_req  in  1  transfer request; sampled only while xfer_ready=1
rd_sel  in  SEL_W  source slot index, captured with xfer_req
wr_mask  in  N_DST  destination one-hot/multi-hot mask, captured with xfer_req
src_data  in  N_SRC*DATA_W  flattened sources; slot k occupies bits [k*DATA_W +: DATA_W]
err_clr  in  1  clears sel_err
xfer_ready  out  1  high when the block can accept a request
busout  out  DATA_W  registered bus value
wr_en  out  N_DST  destination write strobes, one-cycle pulse
xfer_done  out  1  one-cycle pulse marking the end of a transfer
sel_err  out  1  sticky flag: an illegal source was selected
xfer_cnt  out  CNT_W  count of completed legal transfers

Behaviour:
- Reset (async, rst_n=0): state IDLE; busout=0, wr_en=0, xfer_done=0, sel_err=0, xfer_cnt=0, xfer_ready=1; captured rd_sel and wr_mask cleared. Reset asserted mid-transfer aborts it with no wr_en pulse.
- FSM states: IDLE, LOAD, WRITE.
- IDLE: xfer_ready=1. On xfer_req=1, capture rd_sel and wr_mask, then go to LOAD.
- LOAD: xfer_ready=0. A select is legal if rd_sel < N_SRC and SRC_EN[rd_sel]=1.
  - Legal: busout <= the captured source slot's data, sampled at the end of this cycle.
  - Illegal: busout <= 0 if ILLEGAL_ZERO=1, otherwise unchanged; sel_err <= 1.
  - Always go to WRITE.
- WRITE: xfer_ready=0 and xfer_done=1.
  - Legal: wr_en=captured wr_mask; xfer_cnt increments by 1 and wraps from all-ones to 0.
  - Illegal: wr_en=0 and xfer_cnt is unchanged.
  - Next state is IDLE.
- Decode outputs (xfer_done, wr_en) are registered so they are glitch-free; both are high only while in WRITE.
- Latency: request accepted at edge N, busout valid after edge N+1, wr_en/xfer_done high during the cycle after edge N+1, xfer_ready high again after edge N+2. Peak throughput is one transfer per 3 cycles.
- xfer_req while xfer_ready=0 is ignored. It is not queued; the requester must hold it until it sees ready.
- busout holds its value between transfers, so a destination may latch it during WRITE.
- wr_mask=0 with a legal select: completes normally, wr_en stays all zero, and xfer_cnt still increments.
- err_clr: sel_err <= 0. If err_clr and a new illegal LOAD occur in the same cycle, set wins (sel_err=1).
- src_data changes after LOAD have no effect on busout.

Decomposition:
- Shared package bus_pkg: source slot index constants (SRC_IM=0, SRC_PC=1, SRC_DR=2, SRC_TR=4, SRC_AC=5, SRC_R=6, SRC_DM=7), destination bit constants, the FSM state encoding, and the default SRC_EN mask.
- One natural sub-module: bus_src_mux. It is purely combinational: slot select plus legality check, returning the selected data and an illegal flag. The FSM and registers live in bus_xfer_ctrl.

Test Plan:
- Reset then idle: rst_n low mid-LOAD -> all outputs 0, xfer_ready=1, no wr_en pulse; after release, busout stays 0 with no request.
- Legal transfer: src slot 5 = 16'hA5C3, rd_sel=5, wr_mask=8'h04, req at cycle 0 -> busout=16'hA5C3 after cycle 1; wr_en=8'h04 and xfer_done=1 for exactly one cycle; xfer_cnt=1; ready again at cycle 3.
- Illegal slot: rd_sel=3, ILLEGAL_ZERO=1, busout previously 16'h1234 -> busout=0, sel_err=1, wr_en=0, xfer_done pulses, xfer_cnt unchanged; repeat with ILLEGAL_ZERO=0 -> busout stays 16'h1234.
- Back-to-back with held req: rd_sel 0 then 7, wr_mask 8'h81, req held high -> transfers accepted only when ready (3-cycle spacing); wr_en=8'h81 twice; extra requests while busy are not counted.
- Counter wrap and error clear: CNT_W=2, 5 legal transfers -> xfer_cnt sequence 1,2,3,0,1. err_clr together with an illegal LOAD -> sel_err=1; err_clr alone afterwards -> sel_err=0.
- Source change after capture: modify slot 2 during WRITE -> busout keeps the value sampled in LOAD.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared slot indices, FSM encoding and defaults for the bus transfer controller
package bus_pkg;

    // Source slot indices on the bus multiplexer
    localparam int SRC_IM = 0;
    localparam int SRC_PC = 1;
    localparam int SRC_DR = 2;
    localparam int SRC_TR = 4;
    localparam int SRC_AC = 5;
    localparam int SRC_R  = 6;
    localparam int SRC_DM = 7;

    // Destination write-enable bit positions
    localparam int DST_AR  = 0;
    localparam int DST_PC  = 1;
    localparam int DST_DR  = 2;
    localparam int DST_AC  = 3;
    localparam int DST_IR  = 4;
    localparam int DST_TR  = 5;
    localparam int DST_OUT = 6;
    localparam int DST_MEM = 7;

    // Slot 3 is not wired to any register in the default datapath
    localparam logic [7:0] SRC_EN_DEFAULT = 8'b1111_0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2
    } xfer_state_e;

    // Select width for n slots, never narrower than one bit
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_src_mux.sv
// rtl/bus_src_mux.sv - combinational source slot select with legality check
module bus_src_mux #(
    parameter int              DATA_W = 16,
    parameter int              N_SRC  = 8,
    parameter logic [N_SRC-1:0] SRC_EN = '1,
    parameter int              SEL_W  = 3
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [DATA_W-1:0]       sel_data,
    output logic                    illegal
);

    // Pick the addressed slot; an out-of-range or unimplemented slot yields zero and flags illegal
    always_comb begin
        sel_data = '0;
        illegal  = 1'b1;
        for (int k = 0; k < N_SRC; k++) begin
            if (SRC_EN[k] && (sel == SEL_W'(k))) begin
                sel_data = src_data[k*DATA_W +: DATA_W];
                illegal  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - registered bus transfer controller with req/ready/done handshake
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter int               DATA_W       = 16,
    parameter int               N_SRC        = 8,
    parameter int               N_DST        = 8,
    parameter logic [N_SRC-1:0] SRC_EN       = N_SRC'(SRC_EN_DEFAULT),
    parameter bit               ILLEGAL_ZERO = 1'b1,
    parameter int               CNT_W        = 8,
    localparam int              SEL_W        = sel_width(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    xfer_req,
    input  logic [SEL_W-1:0]        rd_sel,
    input  logic [N_DST-1:0]        wr_mask,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic                    err_clr,
    output logic                    xfer_ready,
    output logic [DATA_W-1:0]       busout,
    output logic [N_DST-1:0]        wr_en,
    output logic                    xfer_done,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        xfer_cnt
);

    xfer_state_e       state_q, state_d;
    logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
    logic [N_DST-1:0]  wr_mask_q, wr_mask_d;
    logic [DATA_W-1:0] busout_q, busout_d;
    logic [N_DST-1:0]  wr_en_q, wr_en_d;
    logic              xfer_done_q, xfer_done_d;
    logic              sel_err_q, sel_err_d;
    logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;

    logic [DATA_W-1:0] sel_data;
    logic              sel_illegal;

    // The captured select stays stable through LOAD and WRITE, so one lookup serves both
    bus_src_mux #(
        .DATA_W (DATA_W),
        .N_SRC  (N_SRC),
        .SRC_EN (SRC_EN),
        .SEL_W  (SEL_W)
    ) u_src_mux (
        .sel      (rd_sel_q),
        .src_data (src_data),
        .sel_data (sel_data),
        .illegal  (sel_illegal)
    );

    // Next-state and next-output logic; wr_en/xfer_done are computed in LOAD so they register high for WRITE only
    always_comb begin
        state_d     = state_q;
        rd_sel_d    = rd_sel_q;
        wr_mask_d   = wr_mask_q;
        busout_d    = busout_q;
        wr_en_d     = '0;
        xfer_done_d = 1'b0;
        sel_err_d   = err_clr ? 1'b0 : sel_err_q;
        xfer_cnt_d  = xfer_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_req) begin
                    rd_sel_d  = rd_sel;
                    wr_mask_d = wr_mask;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (sel_illegal) begin
                    // A new error beats a simultaneous clear
                    sel_err_d = 1'b1;
                    if (ILLEGAL_ZERO) begin
                        busout_d = '0;
                    end
                end else begin
                    busout_d = sel_data;
                    wr_en_d  = wr_mask_q;
                end
                xfer_done_d = 1'b1;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                if (!sel_illegal) begin
                    xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_sel_q    <= '0;
            wr_mask_q   <= '0;
            busout_q    <= '0;
            wr_en_q     <= '0;
            xfer_done_q <= 1'b0;
            sel_err_q   <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_sel_q    <= rd_sel_d;
            wr_mask_q   <= wr_mask_d;
            busout_q    <= busout_d;
            wr_en_q     <= wr_en_d;
            xfer_done_q <= xfer_done_d;
            sel_err_q   <= sel_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign xfer_ready = (state_q == ST_IDLE);
    assign busout     = busout_q;
    assign wr_en      = wr_en_q;
    assign xfer_done  = xfer_done_q;
    assign sel_err    = sel_err_q;
    assign xfer_cnt   = xfer_cnt_q;

endmodule
